// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array front-end scheduler.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } sched_state_t;

  // Lane-vector pattern: element i of an N-wide bus; modules re-declare it with their own parameters.
  localparam int unsigned DEF_MATRIX_SIZE = 2;
  localparam int unsigned DEF_DATA_SIZE   = 32;
  typedef logic [DEF_MATRIX_SIZE-1:0][DEF_DATA_SIZE-1:0] lane_vec_t;

  // Cycles after the last vector's first drain cycle until the tag pipelines are empty.
  function automatic int unsigned drain_depth(input int unsigned sum_latency, input int unsigned n);
    return sum_latency + n - 1;
  endfunction

endpackage

// File: rtl/systolic_skew.sv
// Fixed-depth delay line used for lane skew and result tagging.
module systolic_skew #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= din;
      for (int k = 1; k < int'(DEPTH); k++) pipe[k] <= pipe[k-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/systolic_scheduler.sv
// Weight-load / skewed-activation sequencer feeding a weight-stationary systolic array.
module systolic_scheduler
  import systolic_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned SUM_LATENCY = MATRIX_SIZE
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  w_row,
  input  logic                                   d_valid,
  output logic                                   d_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  d_vec,
  input  logic                                   d_last,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  in_data,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  in_weights,
  output logic [MATRIX_SIZE-1:0]                 load_weight,
  output logic [MATRIX_SIZE-1:0]                 enable_mult,
  output logic [MATRIX_SIZE-1:0]                 out_valid,
  output logic                                   busy
);

  localparam int unsigned N       = MATRIX_SIZE;
  localparam int unsigned CNT_W   = $clog2(N + 1);
  localparam int unsigned DRAIN_D = drain_depth(SUM_LATENCY, N);
  localparam int unsigned DCNT_W  = $clog2(DRAIN_D + 2);

  sched_state_t                      state, state_n;
  logic [CNT_W-1:0]                  row_cnt, row_cnt_n;
  logic [DCNT_W-1:0]                 drain_cnt, drain_cnt_n;
  logic                              w_ready_n, d_ready_n, busy_n;
  logic [N-1:0][DATA_SIZE-1:0]       in_weights_n;
  logic [N-1:0]                      load_weight_n;
  logic                              w_xfer, d_xfer;

  assign w_xfer = w_valid & w_ready & ((state == IDLE) | (state == LOAD));
  assign d_xfer = d_valid & d_ready & (state == COMPUTE);

  // Next state, counters and registered-output values.
  always_comb begin
    state_n       = state;
    row_cnt_n     = row_cnt;
    drain_cnt_n   = drain_cnt;
    in_weights_n  = '0;
    load_weight_n = '0;
    case (state)
      IDLE: begin
        if (w_xfer) begin
          row_cnt_n = CNT_W'(1);
          state_n   = (N == 1) ? COMPUTE : LOAD;
        end
      end
      LOAD: begin
        if (w_xfer) begin
          row_cnt_n = row_cnt + CNT_W'(1);
          if (row_cnt_n == CNT_W'(N)) state_n = COMPUTE;
        end
      end
      COMPUTE: begin
        if (d_xfer && d_last) begin
          state_n     = DRAIN;
          drain_cnt_n = DCNT_W'(DRAIN_D);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_n = IDLE;
        else                 drain_cnt_n = drain_cnt - DCNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
    if (w_xfer) begin
      in_weights_n  = w_row;
      load_weight_n = '1;
    end
    w_ready_n = (state_n == IDLE) || (state_n == LOAD);
    d_ready_n = (state_n == COMPUTE);
    busy_n    = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      row_cnt     <= '0;
      drain_cnt   <= '0;
      w_ready     <= 1'b0;
      d_ready     <= 1'b0;
      busy        <= 1'b0;
      in_weights  <= '0;
      load_weight <= '0;
    end else begin
      state       <= state_n;
      row_cnt     <= row_cnt_n;
      drain_cnt   <= drain_cnt_n;
      w_ready     <= w_ready_n;
      d_ready     <= d_ready_n;
      busy        <= busy_n;
      in_weights  <= in_weights_n;
      load_weight <= load_weight_n;
    end
  end

  // Lane i carries {enable, data} delayed i+1 cycles; tags follow lane 0 by SUM_LATENCY + j.
  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    logic [DATA_SIZE:0] lane_in, lane_out;

    assign lane_in = d_xfer ? {1'b1, d_vec[i]} : '0;

    systolic_skew #(.DEPTH(i + 1), .WIDTH(DATA_SIZE + 1)) u_data (
      .clk   (clk),
      .rst_n (reset),
      .din   (lane_in),
      .dout  (lane_out)
    );

    assign enable_mult[i] = lane_out[DATA_SIZE];
    assign in_data[i]     = lane_out[DATA_SIZE-1:0];

    systolic_skew #(.DEPTH(SUM_LATENCY + 1 + i), .WIDTH(1)) u_tag (
      .clk   (clk),
      .rst_n (reset),
      .din   (d_xfer),
      .dout  (out_valid[i])
    );
  end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Scoreboard bench for systolic_scheduler with N=2, SUM_LATENCY=2.
`timescale 1ns/1ps
module tb_systolic_scheduler;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 2;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    logic [DW-1:0] data;
    int unsigned   cyc;
  } lane_exp_t;

  logic         clk = 1'b0;
  logic         reset, w_valid, w_ready, d_valid, d_ready, d_last, busy;
  vec_t         w_row, d_vec, in_data, in_weights;
  logic [N-1:0] load_weight, enable_mult, out_valid;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;
  int unsigned cyc      = 0;
  bit          mon_en   = 1'b0;
  lane_exp_t   lane_q [N][$];
  int unsigned ov_q   [N][$];

  systolic_scheduler #(.MATRIX_SIZE(N), .DATA_SIZE(DW), .SUM_LATENCY(SL)) dut (
    .clk         (clk),
    .reset       (reset),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_row       (w_row),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_vec       (d_vec),
    .d_last      (d_last),
    .in_data     (in_data),
    .in_weights  (in_weights),
    .load_weight (load_weight),
    .enable_mult (enable_mult),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b);
    vec_t v;
    v[0] = a;
    v[1] = b;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record expected lane data and result tags for a vector accepted at the coming edge.
  task automatic push_vec(input vec_t v);
    for (int i = 0; i < int'(N); i++) begin
      lane_q[i].push_back('{data: v[i], cyc: cyc + 1 + i});
      ov_q[i].push_back(cyc + 1 + SL + i);
    end
  endtask

  task automatic drive_vec(input vec_t v, input logic last);
    d_valid = 1'b1;
    d_vec   = v;
    d_last  = last;
    if (d_ready) push_vec(v);
    tick();
    d_valid = 1'b0;
    d_last  = 1'b0;
    d_vec   = '0;
  endtask

  task automatic load_weights(input vec_t ra, input vec_t rb);
    w_valid = 1'b1;
    w_row   = ra;
    tick();
    w_row = rb;
    tick();
    w_valid = 1'b0;
    w_row   = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    else pass_cnt++;
  endtask

  // Scoreboard monitor: each lane and tag is compared every cycle against the queue head.
  initial begin
    logic          exp_en;
    logic [DW-1:0] exp_d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < int'(N); i++) begin
          exp_en = (lane_q[i].size() != 0) && (lane_q[i][0].cyc == cyc);
          exp_d  = exp_en ? lane_q[i][0].data : '0;
          if (exp_en) lane_q[i].delete(0);
          chk_cnt++;
          if (enable_mult[i] !== exp_en || in_data[i] !== exp_d)
            $display("FAIL sb_lane%0d cyc %0d: en=%b data=%0d, required en=%b data=%0d",
                     i, cyc, enable_mult[i], in_data[i], exp_en, exp_d);
          else pass_cnt++;
          exp_en = (ov_q[i].size() != 0) && (ov_q[i][0] == cyc);
          if (exp_en) ov_q[i].delete(0);
          chk_cnt++;
          if (out_valid[i] !== exp_en)
            $display("FAIL sb_out_valid%0d cyc %0d: got %b, required %b", i, cyc, out_valid[i], exp_en);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; w_valid = 1'b0; d_valid = 1'b0; d_last = 1'b0;
    w_row = '0; d_vec = '0;
    tick(); tick();
    chk_cnt++;
    if ({w_ready, d_ready, busy, load_weight, enable_mult, out_valid} !== '0 ||
        in_data !== '0 || in_weights !== '0)
      $display("FAIL reset_outputs: ctl=%b in_data=%h in_weights=%h, required all 0",
               {w_ready, d_ready, busy, load_weight, enable_mult, out_valid}, in_data, in_weights);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    chk_cnt++;
    if (w_ready !== 1'b1 || d_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle: w_ready=%b d_ready=%b busy=%b, required 1 0 0", w_ready, d_ready, busy);
    else pass_cnt++;
    mon_en = 1'b1;
  endtask

  task automatic test_weight_load();
    w_valid = 1'b1; w_row = mk(3, 4);
    tick();
    chk_cnt++;
    if (in_weights !== mk(3, 4) || load_weight !== 2'b11 || w_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL wl_row1: in_weights=%h lw=%b w_ready=%b busy=%b, required %h 11 1 1",
               in_weights, load_weight, w_ready, busy, mk(3, 4));
    else pass_cnt++;
    w_row = mk(1, 2);
    tick();
    w_valid = 1'b0; w_row = '0;
    chk_cnt++;
    if (in_weights !== mk(1, 2) || load_weight !== 2'b11 || d_ready !== 1'b1)
      $display("FAIL wl_row2: in_weights=%h lw=%b d_ready=%b, required %h 11 1",
               in_weights, load_weight, d_ready, mk(1, 2));
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (in_weights !== '0 || load_weight !== 2'b00 || w_ready !== 1'b0)
      $display("FAIL wl_after: in_weights=%h lw=%b w_ready=%b, required 0 00 0", in_weights, load_weight, w_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_vector();
    drive_vec(mk(5, 6), 1'b1);
    chk_cnt++;
    if (in_data[0] !== 32'd5 || enable_mult !== 2'b01)
      $display("FAIL sv_lane0: in_data0=%0d en=%b, required 5 01", in_data[0], enable_mult);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (in_data[1] !== 32'd6 || enable_mult !== 2'b10)
      $display("FAIL sv_lane1: in_data1=%0d en=%b, required 6 10", in_data[1], enable_mult);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 2'b01 || busy !== 1'b1)
      $display("FAIL sv_ov0: out_valid=%b busy=%b, required 01 1", out_valid, busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 2'b10 || busy !== 1'b1)
      $display("FAIL sv_ov1: out_valid=%b busy=%b, required 10 1", out_valid, busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (busy !== 1'b0 || w_ready !== 1'b1)
      $display("FAIL sv_done: busy=%b w_ready=%b, required 0 1", busy, w_ready);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic exp_ov1;
    wait_idle("st_pre");
    load_weights(mk(3, 4), mk(1, 2));
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        chk_cnt++;
        if (d_ready !== 1'b1) $display("FAIL st_ready%0d: d_ready=%b, required 1", k, d_ready);
        else pass_cnt++;
        d_valid = 1'b1; d_vec = mk(DW'(2 * k + 1), DW'(2 * k + 2)); d_last = (k == 3);
        push_vec(d_vec);
      end else begin
        d_valid = 1'b0; d_last = 1'b0; d_vec = '0;
      end
      tick();
      if (k >= 1 && k <= 4) begin
        chk_cnt++;
        if (enable_mult[1] !== 1'b1 || in_data[1] !== DW'(2 * k))
          $display("FAIL st_lane1_%0d: en=%b data=%0d, required 1 %0d", k, enable_mult[1], in_data[1], 2 * k);
        else pass_cnt++;
      end
      exp_ov1 = (k >= 3 && k <= 6);
      chk_cnt++;
      if (out_valid[1] !== exp_ov1)
        $display("FAIL st_ov1_%0d: out_valid1=%b, required %b", k, out_valid[1], exp_ov1);
      else pass_cnt++;
      if (k >= 6) begin
        chk_cnt++;
        if (busy !== (k == 6)) $display("FAIL st_busy%0d: busy=%b, required %b", k, busy, k == 6);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_bubbles_ignored();
    logic [N-1:0] exp_en;
    wait_idle("bi_pre");
    load_weights(mk(7, 7), mk(8, 8));
    for (int k = 0; k < 6; k++) begin
      d_valid = 1'b0; d_last = 1'b0; d_vec = '0; w_valid = 1'b0;
      if (k == 0 || k == 3) begin
        d_valid = 1'b1; d_vec = (k == 0) ? mk(9, 10) : mk(11, 12); d_last = (k == 3);
        if (d_ready) push_vec(d_vec);
      end else if (k == 1 || k == 2) begin
        w_valid = 1'b1; w_row = mk(99, 98); d_last = (k == 1);
      end
      tick();
      exp_en = {(k == 1 || k == 4), (k == 0 || k == 3)};
      chk_cnt++;
      if (enable_mult !== exp_en || load_weight !== 2'b00 || in_weights !== '0)
        $display("FAIL bi_cycle%0d: en=%b lw=%b in_weights=%h, required en=%b lw=00 w=0",
                 k, enable_mult, load_weight, in_weights, exp_en);
      else pass_cnt++;
      if (k == 1 || k == 2) begin
        chk_cnt++;
        if (d_ready !== 1'b1) $display("FAIL bi_still_compute%0d: d_ready=%b, required 1", k, d_ready);
        else pass_cnt++;
      end
    end
    w_valid = 1'b0; w_row = '0;
    wait_idle("bi");
  endtask

  task automatic test_reset_mid();
    load_weights(mk(1, 1), mk(2, 2));
    drive_vec(mk(21, 22), 1'b1);
    tick();
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      lane_q[i].delete();
      ov_q[i].delete();
    end
    #1;
    chk_cnt++;
    if ({w_ready, d_ready, busy, load_weight, enable_mult, out_valid} !== '0 ||
        in_data !== '0 || in_weights !== '0)
      $display("FAIL rm_async_clear: ctl=%b in_data=%h in_weights=%h, required all 0",
               {w_ready, d_ready, busy, load_weight, enable_mult, out_valid}, in_data, in_weights);
    else pass_cnt++;
    tick();
    reset = 1'b1;
    tick();
    chk_cnt++;
    if (w_ready !== 1'b1 || busy !== 1'b0 || d_ready !== 1'b0 || enable_mult !== '0 || out_valid !== '0)
      $display("FAIL rm_idle: w_ready=%b busy=%b d_ready=%b en=%b ov=%b, required 1 0 0 00 00",
               w_ready, busy, d_ready, enable_mult, out_valid);
    else pass_cnt++;
    mon_en = 1'b1;
  endtask

  task automatic test_gapped_load();
    w_valid = 1'b1; w_row = mk(7, 8);
    tick();
    w_valid = 1'b0; w_row = '0;
    chk_cnt++;
    if (load_weight !== 2'b11 || in_weights !== mk(7, 8) || d_ready !== 1'b0)
      $display("FAIL gl_row1: lw=%b in_weights=%h d_ready=%b, required 11 %h 0", load_weight, in_weights, d_ready, mk(7, 8));
    else pass_cnt++;
    for (int g = 0; g < 2; g++) begin
      tick();
      chk_cnt++;
      if (load_weight !== 2'b00 || in_weights !== '0 || d_ready !== 1'b0 || busy !== 1'b1 || w_ready !== 1'b1)
        $display("FAIL gl_gap%0d: lw=%b in_weights=%h d_ready=%b busy=%b w_ready=%b, required 00 0 0 1 1",
                 g, load_weight, in_weights, d_ready, busy, w_ready);
      else pass_cnt++;
    end
    w_valid = 1'b1; w_row = mk(9, 10);
    tick();
    w_valid = 1'b0; w_row = '0;
    chk_cnt++;
    if (load_weight !== 2'b11 || in_weights !== mk(9, 10) || d_ready !== 1'b1)
      $display("FAIL gl_row2: lw=%b in_weights=%h d_ready=%b, required 11 %h 1", load_weight, in_weights, d_ready, mk(9, 10));
    else pass_cnt++;
    drive_vec(mk(31, 32), 1'b1);
    wait_idle("gl");
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_single_vector();
    test_streaming();
    test_bubbles_ignored();
    test_reset_mid();
    test_gapped_load();
    tick(); tick();
    for (int i = 0; i < int'(N); i++) begin
      chk_cnt++;
      if (lane_q[i].size() != 0 || ov_q[i].size() != 0)
        $display("FAIL sb_drain%0d: lane entries=%0d tag entries=%0d left, required 0 0",
                 i, lane_q[i].size(), ov_q[i].size());
      else pass_cnt++;
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
